// File: rtl/matrix_result_uart_tx.sv
// 8N1 UART transmitter returning the systolic product matrix to the host, paced by the uart_rx oversample tick.
// Optional XOR checksum frame after the payload: define UART_TX_CHECKSUM_EN.
module matrix_result_uart_tx #(
  parameter int OVERSAMPLE  = 13,
  parameter int N_DATA_BITS = 8,
  parameter int WORD_WIDTH  = 32,
  parameter int N_WORDS     = 16,
  parameter int N_STOP_BITS = 1
) (
  input  logic                          i_clk,
  input  logic                          i_reset_n,
  input  logic                          i_en,
  input  logic                          i_start,
  input  logic [N_WORDS*WORD_WIDTH-1:0] i_matrix,
  output logic                          o_tx,
  output logic                          o_busy,
  output logic                          o_done
);

  localparam int MAT_W     = N_WORDS * WORD_WIDTH;
  localparam int N_PAYLOAD = MAT_W / N_DATA_BITS;
`ifdef UART_TX_CHECKSUM_EN
  localparam int N_FRAMES  = N_PAYLOAD + 1;
`else
  localparam int N_FRAMES  = N_PAYLOAD;
`endif
  localparam int TICK_W = (N_STOP_BITS * OVERSAMPLE > 1) ? $clog2(N_STOP_BITS * OVERSAMPLE) : 1;
  localparam int BIT_W  = (N_DATA_BITS > 1) ? $clog2(N_DATA_BITS) : 1;
  localparam int IDX_W  = (N_FRAMES > 1) ? $clog2(N_FRAMES) : 1;

  localparam logic [TICK_W-1:0] BIT_LAST   = TICK_W'(OVERSAMPLE - 1);
  localparam logic [TICK_W-1:0] STOP_LAST  = TICK_W'(N_STOP_BITS * OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  DBIT_LAST  = BIT_W'(N_DATA_BITS - 1);
  localparam logic [IDX_W-1:0]  FRAME_LAST = IDX_W'(N_FRAMES - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                   state;
  logic [TICK_W-1:0]        tick_cnt;
  logic [BIT_W-1:0]         bit_idx;
  logic [IDX_W-1:0]         byte_idx;
  logic [MAT_W-1:0]         shadow;
  logic [N_DATA_BITS-1:0]   shift_reg;
  logic [N_DATA_BITS-1:0]   cur_byte;

  // Shadow shifts down one byte per frame, so the next payload byte is always at the bottom.
`ifdef UART_TX_CHECKSUM_EN
  logic [N_DATA_BITS-1:0]   csum;
  always_comb cur_byte = (byte_idx == FRAME_LAST) ? csum : shadow[N_DATA_BITS-1:0];
`else
  assign cur_byte = shadow[N_DATA_BITS-1:0];
`endif

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state     <= IDLE;
      tick_cnt  <= '0;
      bit_idx   <= '0;
      byte_idx  <= '0;
      shadow    <= '0;
      shift_reg <= '0;
      o_tx      <= 1'b1;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
`ifdef UART_TX_CHECKSUM_EN
      csum      <= '0;
`endif
    end else begin
      o_done <= 1'b0;
      case (state)
        IDLE: begin
          // A coincident i_en is not counted toward the start bit.
          if (i_start) begin
            shadow   <= i_matrix;
            state    <= START;
            tick_cnt <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
            o_busy   <= 1'b1;
            o_tx     <= 1'b0;
`ifdef UART_TX_CHECKSUM_EN
            csum     <= '0;
`endif
          end
        end
        START: begin
          if (i_en) begin
            if (tick_cnt == BIT_LAST) begin
              tick_cnt  <= '0;
              bit_idx   <= '0;
              state     <= DATA;
              o_tx      <= cur_byte[0];
              shift_reg <= cur_byte >> 1;
              shadow    <= shadow >> N_DATA_BITS;
`ifdef UART_TX_CHECKSUM_EN
              if (byte_idx != FRAME_LAST) csum <= csum ^ cur_byte;
`endif
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        DATA: begin
          if (i_en) begin
            if (tick_cnt == BIT_LAST) begin
              tick_cnt <= '0;
              if (bit_idx == DBIT_LAST) begin
                state <= STOP;
                o_tx  <= 1'b1;
              end else begin
                bit_idx   <= bit_idx + 1'b1;
                o_tx      <= shift_reg[0];
                shift_reg <= shift_reg >> 1;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        STOP: begin
          if (i_en) begin
            if (tick_cnt == STOP_LAST) begin
              tick_cnt <= '0;
              if (byte_idx == FRAME_LAST) begin
                state    <= IDLE;
                byte_idx <= '0;
                o_busy   <= 1'b0;
                o_done   <= 1'b1;
              end else begin
                byte_idx <= byte_idx + 1'b1;
                state    <= START;
                o_tx     <= 1'b0;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_result_uart_tx.sv
// Scoreboard bench for matrix_result_uart_tx: a line monitor decodes 8N1 frames by counting i_en ticks.
`timescale 1ns/1ps
module tb_matrix_result_uart_tx;
  localparam int OS    = 13;
  localparam int NW    = 16;
  localparam int WW    = 32;
  localparam int MAT_W = NW * WW;
  localparam int N_PAY = MAT_W / 8;
`ifdef UART_TX_CHECKSUM_EN
  localparam int N_FRAMES = N_PAY + 1;
`else
  localparam int N_FRAMES = N_PAY;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             en = 1'b0;
  logic             start = 1'b0;
  logic [MAT_W-1:0] matrix = '0;
  logic             tx, busy, done;

  int          errors = 0;
  int          checks = 0;
  int unsigned tick_no = 0;
  int          frames = 0;
  int          done_cnt = 0;
  bit          in_data = 1'b0;
  bit          en_run = 1'b1;
  int          en_div = 1;
  int          en_cnt = 0;
  logic [7:0]  exp_q[$];

  matrix_result_uart_tx dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_en(en), .i_start(start),
    .i_matrix(matrix), .o_tx(tx), .o_busy(busy), .o_done(done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (en_cnt >= en_div - 1) en_cnt = 0; else en_cnt++;
    en = en_run && (en_cnt == 0);
  end

  always @(posedge clk) if (en) tick_no <= tick_no + 1;
  always @(negedge clk) if (done === 1'b1) done_cnt++;

  // Frame decoder: samples each bit mid-way, OS ticks per bit from the falling edge.
  always begin : mon
    logic        prev_tx;
    logic [9:0]  bits;
    logic [7:0]  got, want;
    int unsigned t0, tgt;
    int          guard;
    bit          ok;
    prev_tx = 1'b1;
    forever begin
      @(negedge clk);
      if (rst_n && prev_tx === 1'b1 && tx === 1'b0) begin
        t0 = tick_no;
        ok = 1'b1;
        for (int j = 0; j < 10 && ok; j++) begin
          tgt = t0 + OS * j + OS / 2;
          guard = 0;
          while (tick_no < tgt && rst_n && guard < 20000) begin
            @(negedge clk);
            guard++;
          end
          if (!rst_n) ok = 1'b0;
          else if (guard >= 20000) begin
            checks++; errors++; ok = 1'b0;
            $display("FAIL mon_timeout: bit %0d never reached (tick %0d, need %0d)", j, tick_no, tgt);
          end else begin
            bits[j] = tx;
            in_data = (j >= 1 && j <= 8);
          end
        end
        in_data = 1'b0;
        if (ok) begin
          got = bits[8:1];
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL frame_extra: got byte %02h, none expected", got);
          end else begin
            want = exp_q.pop_front();
            if (bits[0] !== 1'b0 || bits[9] !== 1'b1 || got !== want) begin
              errors++;
              $display("FAIL frame %0d: got start=%b data=%02h stop=%b, want start=0 data=%02h stop=1",
                       frames, bits[0], got, bits[9], want);
            end
          end
          frames++;
        end
      end
      prev_tx = tx;
    end
  end

  function automatic void push_matrix(input logic [MAT_W-1:0] m);
    logic [7:0] x;
    x = 8'h00;
    for (int b = 0; b < N_PAY; b++) begin
      exp_q.push_back(m[b*8 +: 8]);
      x = x ^ m[b*8 +: 8];
    end
`ifdef UART_TX_CHECKSUM_EN
    exp_q.push_back(x);
`endif
  endfunction

  function automatic logic [MAT_W-1:0] rand_matrix();
    logic [MAT_W-1:0] m;
    for (int k = 0; k < NW; k++) m[k*WW +: WW] = $urandom;
    return m;
  endfunction

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_done(input int max_clk, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < max_clk && !seen; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic wait_frames(input int target);
    for (int i = 0; i < 20000 && frames < target; i++) @(negedge clk);
    checks++;
    if (frames < target) begin
      errors++;
      $display("FAIL frame_wait: frames=%0d, need %0d", frames, target);
    end
  endtask

  task automatic test_reset();
    bit bad;
    rst_n = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      start = 1'($urandom_range(0, 1));
      matrix = rand_matrix();
      checks++;
      if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold: tx=%b busy=%b done=%b, want 1 0 0", tx, busy, done);
      end
    end
    start = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL reset_release_idle: tx=%b busy=%b, want 1 0", tx, busy);
    end
  endtask

  task automatic test_single();
    logic [MAT_W-1:0] m;
    int f0, d0;
    int unsigned t_acc;
    bit seen;
    en_div = 4;
    m = '0;
    m[31:0] = 32'h12345678;
    matrix = m;
    push_matrix(m);
    f0 = frames; d0 = done_cnt;
    pulse_start();
    t_acc = tick_no;
    checks++;
    if (busy !== 1'b1 || tx !== 1'b0) begin
      errors++;
      $display("FAIL start_latency: busy=%b tx=%b, want 1 0", busy, tx);
    end
    wait_done(N_FRAMES * 10 * OS * 4 + 400, seen);
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL single_done: no done pulse seen");
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_with_done: busy=%b on done cycle, want 0", busy);
    end
    checks++;
    if (tick_no - t_acc != N_FRAMES * 10 * OS) begin
      errors++;
      $display("FAIL done_ticks: got %0d ticks, want %0d", tick_no - t_acc, N_FRAMES * 10 * OS);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL done_width: done=%b a cycle later, want 0", done);
    end
    repeat (20) @(negedge clk);
    checks++;
    if (frames - f0 != N_FRAMES || exp_q.size() != 0 || done_cnt - d0 != 1) begin
      errors++;
      $display("FAIL single_counts: frames=%0d pending=%0d dones=%0d, want %0d 0 1",
               frames - f0, exp_q.size(), done_cnt - d0, N_FRAMES);
    end
    en_div = 1;
  endtask

  task automatic test_snapshot();
    logic [MAT_W-1:0] m;
    int d0;
    bit seen;
    m = rand_matrix();
    matrix = m;
    push_matrix(m);
    d0 = done_cnt;
    pulse_start();
    wait_frames(frames + 3);
    @(negedge clk);
    matrix = ~m;
    start = 1'b1;
    repeat (2) @(negedge clk);
    start = 1'b0;
    wait_done(N_FRAMES * 10 * OS + 400, seen);
    repeat (30) @(negedge clk);
    checks++;
    if (!seen || exp_q.size() != 0 || done_cnt - d0 != 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL snapshot: seen=%b pending=%0d dones=%0d busy=%b, want 1 0 1 0",
               seen, exp_q.size(), done_cnt - d0, busy);
    end
  endtask

  task automatic test_stall();
    logic [MAT_W-1:0] m;
    logic lvl;
    bit bad, seen;
    m = rand_matrix();
    matrix = m;
    push_matrix(m);
    pulse_start();
    wait_frames(frames + 2);
    for (int i = 0; i < 2000 && !in_data; i++) @(negedge clk);
    en_run = 1'b0;
    repeat (2) @(negedge clk);
    lvl = tx;
    bad = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (tx !== lvl || busy !== 1'b1) bad = 1'b1;
    end
    checks++;
    if (bad || !in_data) begin
      errors++;
      $display("FAIL stall_hold: tx=%b held=%b busy=%b in_data=%b", tx, lvl, busy, in_data);
    end
    en_run = 1'b1;
    wait_done(N_FRAMES * 10 * OS + 400, seen);
    repeat (5) @(negedge clk);
    checks++;
    if (!seen || exp_q.size() != 0) begin
      errors++;
      $display("FAIL stall_resume: seen=%b pending=%0d, want 1 0", seen, exp_q.size());
    end
  endtask

  task automatic test_abort();
    logic [MAT_W-1:0] m;
    int d0;
    bit seen;
    m = rand_matrix();
    matrix = m;
    push_matrix(m);
    pulse_start();
    wait_frames(frames + 10);
    repeat (40) @(negedge clk);
    d0 = done_cnt;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_immediate: tx=%b busy=%b, want 1 0", tx, busy);
    end
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (200) @(negedge clk);
    checks++;
    if (done_cnt != d0 || tx !== 1'b1) begin
      errors++;
      $display("FAIL abort_no_done: dones=%0d tx=%b, want 0 1", done_cnt - d0, tx);
    end
    m = rand_matrix();
    matrix = m;
    push_matrix(m);
    pulse_start();
    wait_done(N_FRAMES * 10 * OS + 400, seen);
    repeat (5) @(negedge clk);
    checks++;
    if (!seen || exp_q.size() != 0) begin
      errors++;
      $display("FAIL abort_restart: seen=%b pending=%0d, want 1 0", seen, exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    logic [MAT_W-1:0] m1, m2;
    int f0, d0;
    bit seen;
    for (int k = 0; k < NW; k++) m1[k*WW +: WW] = 32'h01020304;
    m2 = '0;
    m2[31:0] = 32'h000000FF;
    matrix = m1;
    push_matrix(m1);
    f0 = frames; d0 = done_cnt;
    pulse_start();
    wait_done(N_FRAMES * 10 * OS + 400, seen);
    start = 1'b1;
    matrix = m2;
    push_matrix(m2);
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (!seen || busy !== 1'b1 || tx !== 1'b0) begin
      errors++;
      $display("FAIL b2b_accept: seen=%b busy=%b tx=%b, want 1 1 0", seen, busy, tx);
    end
    wait_done(N_FRAMES * 10 * OS + 400, seen);
    repeat (20) @(negedge clk);
    checks++;
    if (!seen || exp_q.size() != 0 || frames - f0 != 2 * N_FRAMES || done_cnt - d0 != 2) begin
      errors++;
      $display("FAIL b2b_counts: seen=%b pending=%0d frames=%0d dones=%0d, want 1 0 %0d 2",
               seen, exp_q.size(), frames - f0, done_cnt - d0, 2 * N_FRAMES);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_snapshot();
    test_stall();
    test_abort();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
